// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the CPU bus responder slice: bus widths, the two
// memory-mapped I/O addresses, boot FSM state type and a byte type.
package cpu_bus_pkg;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  localparam logic [AW-1:0] IO_OUT_ADDR = 8'hFF;
  localparam logic [AW-1:0] IO_IN_ADDR  = 8'hFE;

  typedef enum logic {LOAD, RUN} boot_state_t;

  typedef logic [7:0] byte_t;
endpackage

// File: rtl/bus_ram_256x8.sv
// Simple RAM with one asynchronous read port and one synchronous write port.
// Ports:
//   clk_i    - write clock, rising edge
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address (combinational read)
//   rdata_o  - read data, reflects contents before any write on this edge
module bus_ram_256x8 #(
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/cpu_bus_responder.sv
// Memory-side responder for the 8-bit CPU bus: RAM plus an output port
// and an input port mapped into the address space, and a boot loader that
// streams a program image into RAM before releasing the CPU.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   addr, wdata, we, rdata    - CPU bus (rdata is combinational, 0 latency)
//   cpu_run                   - high once the CPU may execute
//   ld_valid/ld_data/ld_last  - loader byte stream in
//   ld_ready                  - loader may transfer (LOAD state only)
//   out_port, out_valid       - output register and one-cycle store strobe
//   in_port                   - external input byte, registered once
module cpu_bus_responder #(
  parameter int unsigned              DEPTH       = 256,
  parameter int unsigned              AW          = cpu_bus_pkg::AW,
  parameter int unsigned              DW          = cpu_bus_pkg::DW,
  parameter logic [AW-1:0]            IO_OUT_ADDR = cpu_bus_pkg::IO_OUT_ADDR,
  parameter logic [AW-1:0]            IO_IN_ADDR  = cpu_bus_pkg::IO_IN_ADDR,
  parameter bit                       BOOT_LOAD   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          we,
  output logic [DW-1:0] rdata,
  output logic          cpu_run,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic [DW-1:0] out_port,
  output logic          out_valid,
  input  logic [DW-1:0] in_port
);
  import cpu_bus_pkg::*;

  localparam boot_state_t RST_STATE = BOOT_LOAD ? LOAD : RUN;

  boot_state_t   state_q, state_d;
  logic [AW-1:0] ld_ptr_q, ld_ptr_d;
  logic [DW-1:0] out_port_q, out_port_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] in_reg_q;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          is_io_out;
  logic          is_io_in;

  assign is_io_out = (addr == IO_OUT_ADDR);
  assign is_io_in  = (addr == IO_IN_ADDR);

  // Gated by rst so ld_ready is low throughout the reset cycle, whatever
  // state the register currently holds.
  assign ld_ready = (state_q == LOAD) && !rst;

  // Write port shared between loader (LOAD) and CPU (RUN); the states are
  // exclusive so there is never a collision.
  always_comb begin
    state_d     = state_q;
    ld_ptr_d    = ld_ptr_q;
    out_port_d  = out_port_q;
    out_valid_d = 1'b0;
    ram_we      = 1'b0;
    ram_waddr   = addr;
    ram_wdata   = wdata;
    unique case (state_q)
      LOAD: begin
        if (ld_valid && ld_ready) begin
          ram_we    = 1'b1;
          ram_waddr = ld_ptr_q;
          ram_wdata = ld_data;
          ld_ptr_d  = ld_ptr_q + 1'b1;
          if (ld_last || ld_ptr_q == AW'(DEPTH - 1)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (we && !rst) begin
          if (is_io_out) begin
            out_port_d  = wdata;
            out_valid_d = 1'b1;
          end else if (!is_io_in) begin
            ram_we = 1'b1;
          end
        end
      end
      default: state_d = RST_STATE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RST_STATE;
      ld_ptr_q    <= '0;
      out_port_q  <= '0;
      out_valid_q <= 1'b0;
      in_reg_q    <= '0;
    end else begin
      state_q     <= state_d;
      ld_ptr_q    <= ld_ptr_d;
      out_port_q  <= out_port_d;
      out_valid_q <= out_valid_d;
      in_reg_q    <= in_port;
    end
  end

  bus_ram_256x8 #(
    .AW (AW),
    .DW (DW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (addr),
    .rdata_o (ram_rdata)
  );

  // While loading, the CPU sees zeros (NOP); in RUN the I/O addresses
  // shadow the RAM cells beneath them.
  always_comb begin
    rdata = '0;
    if (state_q == RUN) begin
      if (is_io_in) begin
        rdata = in_reg_q;
      end else if (is_io_out) begin
        rdata = out_port_q;
      end else begin
        rdata = ram_rdata;
      end
    end
  end

  assign cpu_run   = (state_q == RUN);
  assign out_port  = out_port_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_cpu_bus_responder.sv
module tb_cpu_bus_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;
  logic       cpu_run;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic [7:0] out_port;
  logic       out_valid;
  logic [7:0] in_port;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [7:0] model_mem [256];
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  cpu_bus_responder #(
    .DEPTH       (256),
    .AW          (8),
    .DW          (8),
    .IO_OUT_ADDR (8'hFF),
    .IO_IN_ADDR  (8'hFE),
    .BOOT_LOAD   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .we        (we),
    .rdata     (rdata),
    .cpu_run   (cpu_run),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .out_port  (out_port),
    .out_valid (out_valid),
    .in_port   (in_port)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Inputs change at negedge; sampling happens 1ns later, far from posedge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Scoreboard read: expected value queued when the address is driven,
  // popped and compared once rdata has settled.
  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] expv);
    addr = a;
    exp_q.push_back(expv);
    #1;
    chk(tag, rdata, exp_q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b0; we = 1'b0;
    #1;
    chk("ld_ready_in_reset", {7'b0, ld_ready}, 8'h00);
    step();
    rst = 1'b0;
    #1;
    chk("cpu_run_after_reset", {7'b0, cpu_run}, 8'h00);
    chk("out_valid_after_reset", {7'b0, out_valid}, 8'h00);
  endtask

  task automatic load_byte(input string tag, input int unsigned idx, input logic [7:0] b,
                           input logic last);
    ld_valid = 1'b1; ld_data = b; ld_last = last;
    #1;
    chk({tag, "_ld_ready"}, {7'b0, ld_ready}, 8'h01);
    chk({tag, "_cpu_run_low"}, {7'b0, cpu_run}, 8'h00);
    model_mem[idx] = b;
    step();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  initial begin
    logic [7:0] img [5];
    img = '{8'h01, 8'h10, 8'hFF, 8'h00, 8'hAA};
    rst = 1'b1; addr = '0; wdata = '0; we = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; in_port = '0;

    // Reset state
    do_reset();
    chk("out_port_after_reset", out_port, 8'h00);
    chk("ld_ready_load", {7'b0, ld_ready}, 8'h01);
    rd("rdata_zero_in_load", 8'h00, 8'h00);

    // Short image with ld_last on the fifth byte
    for (int i = 0; i < 5; i++) load_byte("img5", i, img[i], i == 4);
    #1;
    chk("img5_cpu_run", {7'b0, cpu_run}, 8'h01);
    chk("img5_ld_ready_off", {7'b0, ld_ready}, 8'h00);
    for (int i = 0; i < 5; i++) rd("img5_readback", 8'(i), model_mem[i]);

    // Full 256-byte image without ld_last
    do_reset();
    for (int i = 0; i < 256; i++) begin
      ld_valid = 1'b1; ld_data = 8'(i) ^ 8'h5C; ld_last = 1'b0;
      model_mem[i] = 8'(i) ^ 8'h5C;
      #1;
      if (i == 0 || i == 254 || i == 255) begin
        chk("full_ld_ready", {7'b0, ld_ready}, 8'h01);
        chk("full_cpu_run_low", {7'b0, cpu_run}, 8'h00);
      end
      step();
    end
    // Keep ld_valid high a further cycle: must be ignored in RUN
    ld_data = 8'hEE;
    #1;
    chk("full_cpu_run", {7'b0, cpu_run}, 8'h01);
    chk("full_ld_ready_off", {7'b0, ld_ready}, 8'h00);
    chk("full_mem_ff", dut.u_ram.mem[255], 8'hA3);
    step();
    ld_valid = 1'b0;
    rd("full_no_wrap_mem0", 8'h00, model_mem[0]);
    rd("full_mem_80", 8'h80, model_mem[128]);

    // Output port store
    addr = 8'hFF; wdata = 8'h5A; we = 1'b1;
    step();
    we = 1'b0;
    #1;
    chk("out_port_5a", out_port, 8'h5A);
    chk("out_valid_pulse", {7'b0, out_valid}, 8'h01);
    chk("out_mem_ff_kept", dut.u_ram.mem[255], 8'hA3);
    step();
    chk("out_valid_drop", {7'b0, out_valid}, 8'h00);
    rd("out_readback", 8'hFF, 8'h5A);

    // we held two cycles gives two stores and two strobes
    addr = 8'hFF; wdata = 8'h11; we = 1'b1;
    step();
    wdata = 8'h22;
    #1;
    chk("out_burst1_valid", {7'b0, out_valid}, 8'h01);
    chk("out_burst1_port", out_port, 8'h11);
    step();
    we = 1'b0;
    #1;
    chk("out_burst2_valid", {7'b0, out_valid}, 8'h01);
    chk("out_burst2_port", out_port, 8'h22);
    step();
    chk("out_burst_end", {7'b0, out_valid}, 8'h00);

    // Input port: one register stage
    in_port = 8'hC3;
    rd("in_before_edge", 8'hFE, 8'h00);
    step();
    rd("in_after_edge", 8'hFE, 8'hC3);
    wdata = 8'h99; we = 1'b1;
    step();
    we = 1'b0;
    #1;
    chk("in_store_ignored_mem", dut.u_ram.mem[254], model_mem[254]);
    rd("in_store_ignored_rd", 8'hFE, 8'hC3);
    chk("in_store_no_strobe", {7'b0, out_valid}, 8'h00);

    // Read-during-write at addr 0x20
    addr = 8'h20; wdata = 8'h77; we = 1'b1;
    rd("rdw_old", 8'h20, model_mem[32]);
    step();
    we = 1'b0;
    model_mem[32] = 8'h77;
    rd("rdw_new", 8'h20, 8'h77);

    // Reset mid-load, then a 2-byte image
    do_reset();
    load_byte("abort", 0, 8'hE1, 1'b0);
    load_byte("abort", 1, 8'hE2, 1'b0);
    load_byte("abort", 2, 8'hE3, 1'b0);
    do_reset();
    load_byte("reload", 0, 8'hD0, 1'b0);
    load_byte("reload", 1, 8'hD1, 1'b1);
    #1;
    chk("reload_cpu_run", {7'b0, cpu_run}, 8'h01);
    rd("reload_a0", 8'h00, 8'hD0);
    rd("reload_a1", 8'h01, 8'hD1);
    rd("reload_a2_kept", 8'h02, 8'hE3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
